regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_pkg.sv | 26 ++
 rtl/wb_fifo.sv | 69 ++++++
 rtl/regfile_write_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Purpose: shared register-file constants, the write-request record and the hazard-match helper.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
// Ports: none.
package regfile_write_arbiter_pkg;

   localparam int REG_COUNT  = 32;
   localparam int REG_ADDR_W = $clog2(REG_COUNT);   // 5
   localparam int DEF_DATA_W = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = '0;

   // Write request at the default data width; the top re-declares it for its own N.
   typedef struct packed {
      reg_addr_t             addr;
      logic [DEF_DATA_W-1:0] data;
   } wr_req_t;

   // A read address collides with a pending write; register 0 never collides.
   function automatic logic addr_match(input reg_addr_t rd, input reg_addr_t wa, input logic vld);
      return vld && (rd != ZERO_REG) && (rd == wa);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Purpose: per-requester writeback queue of DEPTH {addr, data} entries with per-entry visibility.
// Latency: an entry pushed at edge k is at the head after edge k (no bypass).
// Backpressure: full comes only from registered occupancy; no push is taken while full.
// Ports: clk/rst; push + push_req enqueue; pop dequeues head; full/empty flags;
//        head = oldest entry; ent_vld/ent_addr expose every slot for hazard compare.
module wb_fifo
   import regfile_write_arbiter_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type req_t = wr_req_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  req_t                   push_req,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output req_t                   head,
   output logic      [DEPTH-1:0]  ent_vld,
   output reg_addr_t [DEPTH-1:0]  ent_addr
);

   localparam int PTR_W = $clog2(DEPTH);

   req_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [DEPTH-1:0] vld;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   // A push and a pop never target the same slot: that needs the queue both full and empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         vld    <= '0;
      end else begin
         if (pop) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + PTR_W'(1);
         end
         if (push) begin
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
      end
   end

   // Payload needs no reset: a slot is only observed while its valid bit is set.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_req;
      end
   end

   assign full    = &vld;
   assign empty   = ~|vld;
   assign head    = mem[rd_ptr];
   assign ent_vld = vld;

   always_comb begin
      ent_addr = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_addr[i] = mem[i].addr;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Purpose: merges ALU and memory-unit writebacks into the single register-file write port, round-robin.
// Latency: a write accepted at edge k drives RegWrite after edge k+1 at the earliest.
// Backpressure: wrX_ready = queue X not full (registered); addr-0 writes are accepted and dropped.
// Ports: clk, rst (sync, active-high); wr0_*/wr1_* valid-ready write requesters;
//        ReadRegister1/2 -> Hazard1/2 pending-write flags; RegWrite/WriteRegister/WriteData
//        register-file write port; idle = nothing queued or in the output stage.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int N     = 32,
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr0_valid,
   output logic                  wr0_ready,
   input  logic [REG_ADDR_W-1:0] wr0_addr,
   input  logic [N-1:0]          wr0_data,
   input  logic                  wr1_valid,
   output logic                  wr1_ready,
   input  logic [REG_ADDR_W-1:0] wr1_addr,
   input  logic [N-1:0]          wr1_data,
   input  logic [REG_ADDR_W-1:0] ReadRegister1,
   input  logic [REG_ADDR_W-1:0] ReadRegister2,
   output logic                  Hazard1,
   output logic                  Hazard2,
   output logic                  RegWrite,
   output logic [REG_ADDR_W-1:0] WriteRegister,
   output logic [N-1:0]          WriteData,
   output logic                  idle
);

   typedef struct packed {
      reg_addr_t    addr;
      logic [N-1:0] data;
   } req_t;

   req_t                  req0, req1, head0, head1;
   logic                  push0, push1, gnt0, gnt1;
   logic                  full0, full1, empty0, empty1;
   logic      [DEPTH-1:0] ent_vld0, ent_vld1;
   reg_addr_t [DEPTH-1:0] ent_addr0, ent_addr1;
   logic                  rr_sel;   // 0: requester 0 wins a tie, 1: requester 1 wins

   assign req0 = '{addr: wr0_addr, data: wr0_data};
   assign req1 = '{addr: wr1_addr, data: wr1_data};

   assign wr0_ready = ~full0;
   assign wr1_ready = ~full1;

   // Writes to register 0 complete the handshake but never occupy a slot.
   assign push0 = wr0_valid & ~full0 & (wr0_addr != ZERO_REG);
   assign push1 = wr1_valid & ~full1 & (wr1_addr != ZERO_REG);

   assign gnt0 = ~empty0 & (empty1 | ~rr_sel);
   assign gnt1 = ~empty1 & (empty0 |  rr_sel);

   wb_fifo #(.DEPTH(DEPTH), .req_t(req_t)) u_fifo0 (
      .clk(clk), .rst(rst), .push(push0), .push_req(req0), .pop(gnt0),
      .full(full0), .empty(empty0), .head(head0), .ent_vld(ent_vld0), .ent_addr(ent_addr0)
   );

   wb_fifo #(.DEPTH(DEPTH), .req_t(req_t)) u_fifo1 (
      .clk(clk), .rst(rst), .push(push1), .push_req(req1), .pop(gnt1),
      .full(full1), .empty(empty1), .head(head1), .ent_vld(ent_vld1), .ent_addr(ent_addr1)
   );

   // Output stage: address/data hold their last value when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_sel        <= 1'b0;
         RegWrite      <= 1'b0;
         WriteRegister <= '0;
         WriteData     <= '0;
      end else begin
         RegWrite <= gnt0 | gnt1;
         if (gnt0) begin
            rr_sel        <= 1'b1;
            WriteRegister <= head0.addr;
            WriteData     <= head0.data;
         end else if (gnt1) begin
            rr_sel        <= 1'b0;
            WriteRegister <= head1.addr;
            WriteData     <= head1.data;
         end
      end
   end

   // A read sees a hazard against every queued entry and the write being committed now.
   always_comb begin
      Hazard1 = addr_match(ReadRegister1, WriteRegister, RegWrite);
      Hazard2 = addr_match(ReadRegister2, WriteRegister, RegWrite);
      for (int i = 0; i < DEPTH; i++) begin
         Hazard1 = Hazard1 | addr_match(ReadRegister1, ent_addr0[i], ent_vld0[i])
                           | addr_match(ReadRegister1, ent_addr1[i], ent_vld1[i]);
         Hazard2 = Hazard2 | addr_match(ReadRegister2, ent_addr0[i], ent_vld0[i])
                           | addr_match(ReadRegister2, ent_addr1[i], ent_vld1[i]);
      end
   end

   assign idle = empty0 & empty1 & ~RegWrite;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose: self-checking bench for regfile_write_arbiter (vector table, directed corners, random vs. queue model).
// Latency: not applicable.
// Backpressure: the bench honours wrX_ready as a valid-ready source.
module tb_regfile_write_arbiter;

   localparam int N     = 32;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        v0, v1;
   logic [4:0]  a0, a1;
   logic [31:0] d0, d1;
   logic [4:0]  r1, r2;
   logic        wr0_ready, wr1_ready, Hazard1, Hazard2, RegWrite, idle;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData;

   always #5 clk = ~clk;

   regfile_write_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .wr0_valid(v0), .wr0_ready(wr0_ready), .wr0_addr(a0), .wr0_data(d0),
      .wr1_valid(v1), .wr1_ready(wr1_ready), .wr1_addr(a1), .wr1_data(d1),
      .ReadRegister1(r1), .ReadRegister2(r2),
      .Hazard1(Hazard1), .Hazard2(Hazard2),
      .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
      .idle(idle)
   );

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model: two queues, a turn bit, one output register -------------
   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   ent_t        q0[$], q1[$];
   logic        m_turn;
   logic        m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;

   function automatic logic m_haz(input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      if (m_we && m_wa == r) return 1'b1;
      foreach (q0[i]) if (q0[i].addr == r) return 1'b1;
      foreach (q1[i]) if (q1[i].addr == r) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step();
      logic take0, take1;
      ent_t e;
      take0 = v0 && (q0.size() < DEPTH);
      take1 = v1 && (q1.size() < DEPTH);
      if (rst) begin
         q0.delete(); q1.delete();
         m_turn = 1'b0; m_we = 1'b0; m_wa = '0; m_wd = '0;
         return;
      end
      m_we = 1'b0;
      if (q0.size() > 0 && (q1.size() == 0 || m_turn == 1'b0)) begin
         e = q0.pop_front(); m_we = 1'b1; m_wa = e.addr; m_wd = e.data; m_turn = 1'b1;
      end else if (q1.size() > 0) begin
         e = q1.pop_front(); m_we = 1'b1; m_wa = e.addr; m_wd = e.data; m_turn = 1'b0;
      end
      if (take0 && a0 != 5'd0) q0.push_back('{addr: a0, data: d0});
      if (take1 && a1 != 5'd0) q1.push_back('{addr: a1, data: d1});
   endtask

   task automatic chk_model();
      chk("wr0_ready",     64'(wr0_ready),     64'(q0.size() < DEPTH));
      chk("wr1_ready",     64'(wr1_ready),     64'(q1.size() < DEPTH));
      chk("RegWrite",      64'(RegWrite),      64'(m_we));
      chk("WriteRegister", 64'(WriteRegister), 64'(m_wa));
      chk("WriteData",     64'(WriteData),     64'(m_wd));
      chk("Hazard1",       64'(Hazard1),       64'(m_haz(r1)));
      chk("Hazard2",       64'(Hazard2),       64'(m_haz(r2)));
      chk("idle",          64'(idle),          64'(q0.size() == 0 && q1.size() == 0 && !m_we));
   endtask

   // ---------------- cycle driver ----------------------------------------------------------------
   ent_t seen[$];       // commits observed on the write port
   ent_t sent0[$], sent1[$];
   logic acc0, acc1;

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic cycle(input bit use_model);
      #1;
      if (use_model) chk_model();
      if (RegWrite) seen.push_back('{addr: WriteRegister, data: WriteData});
      acc0 = v0 && wr0_ready && !rst;
      acc1 = v1 && wr1_ready && !rst;
      if (acc0 && a0 != 5'd0) sent0.push_back('{addr: a0, data: d0});
      if (acc1 && a1 != 5'd0) sent1.push_back('{addr: a1, data: d1});
      tick();
   endtask

   task automatic idle_inputs();
      v0 = 1'b0; a0 = '0; d0 = '0;
      v1 = 1'b0; a1 = '0; d1 = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      cycle(1'b0);
      rst = 1'b0;
      seen.delete(); sent0.delete(); sent1.delete();
   endtask

   // ---------------- vector table ---------------------------------------------------------------
   typedef struct {
      logic        v0; logic [4:0] a0; logic [31:0] d0;
      logic        v1; logic [4:0] a1; logic [31:0] d1;
      logic [4:0]  r1; logic [4:0] r2;
      logic        we; logic [4:0] wa; logic [31:0] wd;
      logic        h1; logic h2; logic idl;
   } vec_t;

   function automatic vec_t mk(input logic v0_, input logic [4:0] a0_, input logic [31:0] d0_,
                               input logic v1_, input logic [4:0] a1_, input logic [31:0] d1_,
                               input logic [4:0] r1_, input logic [4:0] r2_,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic h1, input logic h2, input logic idl);
      vec_t v;
      v.v0 = v0_; v.a0 = a0_; v.d0 = d0_; v.v1 = v1_; v.a1 = a1_; v.d1 = d1_;
      v.r1 = r1_; v.r2 = r2_; v.we = we; v.wa = wa; v.wd = wd;
      v.h1 = h1; v.h2 = h2; v.idl = idl;
      return v;
   endfunction

   vec_t tbl[11];
   logic [4:0] exp_order[6] = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13};

   initial begin
      int i0, i1;
      bit saw_full0;
      ent_t c0[$], c1[$];

      // Expectations are the outputs visible during the row, before its inputs are clocked.
      tbl[0]  = mk(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1);
      tbl[1]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0);
      tbl[2]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
      tbl[3]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 5'd5, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1);
      tbl[4]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 1'b0, 5'd5, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1);
      tbl[5]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd7, 1'b0, 5'd5, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1);
      tbl[6]  = mk(1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22,       5'd0, 5'd7, 1'b0, 5'd5, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1);
      tbl[7]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd7, 1'b0, 5'd5, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0);
      tbl[8]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd7, 1'b1, 5'd7, 32'h22,       1'b0, 1'b1, 1'b0);
      tbl[9]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd7, 1'b1, 5'd7, 32'h11,       1'b0, 1'b1, 1'b0);
      tbl[10] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd7, 1'b0, 5'd7, 32'h11,       1'b0, 1'b0, 1'b1);

      r1 = '0; r2 = '0;
      idle_inputs();
      rst = 1'b1;
      cycle(1'b0);
      cycle(1'b0);
      rst = 1'b0;

      // Single write latency, hazard window, addr-0 drop, round-robin tie.
      foreach (tbl[i]) begin
         v0 = tbl[i].v0; a0 = tbl[i].a0; d0 = tbl[i].d0;
         v1 = tbl[i].v1; a1 = tbl[i].a1; d1 = tbl[i].d1;
         r1 = tbl[i].r1; r2 = tbl[i].r2;
         #1;
         chk($sformatf("tbl%0d_RegWrite", i),      64'(RegWrite),      64'(tbl[i].we));
         chk($sformatf("tbl%0d_WriteRegister", i), 64'(WriteRegister), 64'(tbl[i].wa));
         chk($sformatf("tbl%0d_WriteData", i),     64'(WriteData),     64'(tbl[i].wd));
         chk($sformatf("tbl%0d_Hazard1", i),       64'(Hazard1),       64'(tbl[i].h1));
         chk($sformatf("tbl%0d_Hazard2", i),       64'(Hazard2),       64'(tbl[i].h2));
         chk($sformatf("tbl%0d_idle", i),          64'(idle),          64'(tbl[i].idl));
         chk($sformatf("tbl%0d_wr0_ready", i),     64'(wr0_ready),     64'd1);
         chk($sformatf("tbl%0d_wr1_ready", i),     64'(wr1_ready),     64'd1);
         tick();
      end

      // Both requesters stream three writes each: interleaved commit order.
      r1 = 5'd2; r2 = 5'd12;
      do_reset();
      i0 = 0; i1 = 0;
      for (int c = 0; c < 20; c++) begin
         v0 = (i0 < 3); a0 = 5'(i0 + 1);  d0 = 32'(100 + i0);
         v1 = (i1 < 3); a1 = 5'(i1 + 11); d1 = 32'(200 + i1);
         cycle(1'b1);
         if (acc0) i0++;
         if (acc1) i1++;
      end
      chk("order_len", 64'(seen.size()), 64'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < seen.size()) chk($sformatf("order_%0d", k), 64'(seen[k].addr), 64'(exp_order[k]));
      end

      // Saturating both requesters: queue 0 fills, nothing lost, per-requester order kept.
      do_reset();
      saw_full0 = 1'b0;
      i0 = 0; i1 = 0;
      for (int c = 0; c < 40; c++) begin
         v0 = 1'b1; a0 = 5'($urandom_range(1, 31)); d0 = 32'(i0);
         v1 = 1'b1; a1 = 5'($urandom_range(1, 31)); d1 = 32'h8000_0000 | 32'(i1);
         #1;
         if (!wr0_ready) saw_full0 = 1'b1;
         cycle(1'b1);
         if (acc0) i0++;
         if (acc1) i1++;
      end
      idle_inputs();
      for (int c = 0; c < 10; c++) cycle(1'b1);
      chk("ready0_dropped", 64'(saw_full0), 64'd1);
      foreach (seen[k]) begin
         if (seen[k].data[31]) c1.push_back(seen[k]);
         else c0.push_back(seen[k]);
      end
      chk("req0_count", 64'(c0.size()), 64'(sent0.size()));
      chk("req1_count", 64'(c1.size()), 64'(sent1.size()));
      foreach (c0[k]) if (k < sent0.size()) chk($sformatf("req0_item%0d", k), 64'(c0[k]), 64'(sent0[k]));
      foreach (c1[k]) if (k < sent1.size()) chk($sformatf("req1_item%0d", k), 64'(c1[k]), 64'(sent1[k]));

      // Two queued writes discarded by a mid-operation reset.
      do_reset();
      v0 = 1'b1; a0 = 5'd9;  d0 = 32'h9;
      v1 = 1'b1; a1 = 5'd10; d1 = 32'hA;
      cycle(1'b1);
      idle_inputs();
      rst = 1'b1;
      cycle(1'b1);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) cycle(1'b1);
      chk("rst_no_commit", 64'(seen.size()), 64'd0);
      #1;
      chk("rst_idle",   64'(idle),      64'd1);
      chk("rst_ready0", 64'(wr0_ready), 64'd1);
      chk("rst_ready1", 64'(wr1_ready), 64'd1);
      tick();

      // Random traffic, small address range to provoke hazards and addr-0 drops.
      for (int c = 0; c < 600; c++) begin
         v0 = 1'($urandom_range(0, 1)); a0 = 5'($urandom_range(0, 7)); d0 = $urandom;
         v1 = 1'($urandom_range(0, 1)); a1 = 5'($urandom_range(0, 7)); d1 = $urandom;
         r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7));
         rst = ($urandom_range(0, 63) == 0);
         cycle(1'b1);
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
